dds_poly_seq: RTL and testbench
===============================

# dds_poly_seq

Sequencer for the DDS polynomial cosine evaluator. It accepts one reduced phase argument per transaction and loads it into the cosine address generator. It then walks the coefficient ROM for the selected segment from the highest polynomial order down to order 0, and strobes the Horner MAC (load, then multiply-accumulate steps). It signals completion when the MAC result is valid. It sits between the phase-reduction front end and the AGU/coefficient-ROM/MAC datapath.

## Interface

Parameters:
- DATA_WIDTH, 16, argument width (Q3.13 signed)
- ADDR_WIDTH, 5, AGU segment address width
- ORDER, 3, polynomial degree; ORDER+1 coefficients per segment
- ORD_WIDTH, 2, order-field width; must satisfy 2^ORD_WIDTH > ORDER

Ports:
- seq_clock_in  in  1  single clock, rising edge
- seq_reset_in  in  1  asynchronous reset, active-high
- seq_valid_in  in  1  argument valid
- seq_ready_out  out  1  sequencer can accept an argument
- seq_urgn_in  in  DATA_WIDTH  signed reduced argument
- seq_agu_control_out  out  1  AGU capture enable
- seq_agu_urgn_out  out  DATA_WIDTH  argument driven to the AGU
- seq_agu_address_in  in  ADDR_WIDTH  registered segment address from the AGU
- seq_rom_address_out  out  ADDR_WIDTH+ORD_WIDTH  coefficient ROM address {segment, order}
- seq_mac_load_out  out  1  MAC: acc <= coef
- seq_mac_step_out  out  1  MAC: acc <= acc*x + coef
- seq_busy_out  out  1  transaction in flight
- seq_done_out  out  1  one-cycle pulse, MAC result valid

## Operation

- FSM states and transitions:
  - IDLE: on valid&ready, go to CAPTURE.
  - CAPTURE: always go to SEG.
  - SEG: always go to EVAL.
  - EVAL: stay for ORDER+1 cycles, then go to DRAIN.
  - DRAIN: always go to DONE.
  - DONE: go to CAPTURE if a new argument is accepted, otherwise go to IDLE.
- seq_ready_out is high in IDLE and DONE only. seq_valid_in is ignored in all other states.
- Accept: register seq_agu_urgn_out from seq_urgn_in.
- CAPTURE: seq_agu_control_out is high for exactly this cycle. The AGU registers at the end of the cycle.
- SEG: latch seq_agu_address_in as the segment. Load the order counter with ORDER.
- EVAL: seq_rom_address_out = {segment, k} for k = ORDER down to 0, one value per cycle. The counter decrements and never wraps below 0.
- The ROM has a synchronous 1-cycle read:
  - seq_mac_load_out is high in the first cycle after the first EVAL cycle.
  - seq_mac_step_out is high in each of the following ORDER cycles.
  - The two strobes are never high together.
- seq_busy_out is high from CAPTURE through DRAIN.
- All outputs are registered.

## Timing

- Reset value of every output is 0, except seq_ready_out, which is 1.
- Reset is honoured mid-transaction: the FSM returns to IDLE, no done pulse is issued and strobes are cleared immediately.
- Cycle timeline with accept edge at cycle 0 and ORDER=3:
  - cycle 1: agu_control
  - cycle 2: SEG
  - cycles 3-6: ROM addresses
  - cycle 4: mac_load
  - cycles 5-7: mac_step
  - cycle 8: seq_done_out
- Generally, done is asserted at cycle ORDER+5.
- Back-to-back: an accept in DONE produces the next agu_control in the following cycle. Sustained period is ORDER+5 cycles.
- Arithmetic: the order counter is ORD_WIDTH bits, unsigned. The segment is taken verbatim from the AGU, including the AGU default 0 for negative or sub-segment arguments.

## Configuration

- DDS_SEQ_FOLD_EN defined:
  - At accept, seq_agu_urgn_out = |seq_urgn_in| (cosine even symmetry).
  - The most negative value 0x8000 saturates to 0x7FFF.
- DDS_SEQ_FOLD_EN undefined: seq_urgn_in is passed unmodified.
- Timing is identical in both builds.

## Structure

- Shared package dds_seq_pkg:
  - FSM state enum (IDLE, CAPTURE, SEG, EVAL, DRAIN, DONE)
  - default ORDER/ORD_WIDTH constants
  - ROM address concatenation helper width
- One natural sub-module: dds_seq_fold, a combinational absolute-value with saturation. It is instantiated only under DDS_SEQ_FOLD_EN.

## Test plan

- Basic segment walk: seq_urgn_in=0x1400 (segment 5), ORDER=3 -> seq_agu_control_out high at cycle 1; seq_rom_address_out 0x17, 0x16, 0x15, 0x14 at cycles 3-6; mac_load at cycle 4; mac_step at cycles 5-7; done at cycle 8.
- Fold with DDS_SEQ_FOLD_EN: 0xEC00 -> seq_agu_urgn_out=0x1400, addresses 0x17..0x14.
- Fold edge with DDS_SEQ_FOLD_EN: 0x8000 -> seq_agu_urgn_out=0x7FFF, segment 31, addresses 0x7F..0x7C.
- No fold (macro undefined): 0xEC00 passed unchanged; AGU returns segment 0; addresses 0x03..0x00.
- Back-to-back: seq_valid_in held high with two arguments -> second accept in the DONE cycle (cycle 8); done pulses at cycles 8 and 16.
- Busy and reset: valid pulsed at cycles 3-5 -> ignored, seq_ready_out stays 0.
- Reset in EVAL: seq_reset_in asserted at cycle 4 -> all strobes and busy drop to 0 immediately, ready=1, no done; a fresh transaction after release completes normally.

Source files
------------

// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS polynomial cosine sequencer.
package dds_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEG,
    EVAL,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int DEF_ORDER     = 3;
  localparam int DEF_ORD_WIDTH = 2;

  // ROM address is {segment, order}.
  function automatic int rom_addr_width(input int addr_w, input int ord_w);
    return addr_w + ord_w;
  endfunction

endpackage

// File: rtl/dds_poly_seq_if.sv
// Sequencer-facing bus: phase-reduction handshake plus AGU/ROM/MAC controls.
interface dds_poly_seq_if import dds_seq_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int ORD_WIDTH  = DEF_ORD_WIDTH
);

  localparam int ROM_W = rom_addr_width(ADDR_WIDTH, ORD_WIDTH);

  logic                  seq_valid_in;
  logic                  seq_ready_out;
  logic [DATA_WIDTH-1:0] seq_urgn_in;
  logic                  seq_agu_control_out;
  logic [DATA_WIDTH-1:0] seq_agu_urgn_out;
  logic [ADDR_WIDTH-1:0] seq_agu_address_in;
  logic [ROM_W-1:0]      seq_rom_address_out;
  logic                  seq_mac_load_out;
  logic                  seq_mac_step_out;
  logic                  seq_busy_out;
  logic                  seq_done_out;

  modport master (
    output seq_valid_in, seq_urgn_in, seq_agu_address_in,
    input  seq_ready_out, seq_agu_control_out, seq_agu_urgn_out,
           seq_rom_address_out, seq_mac_load_out, seq_mac_step_out,
           seq_busy_out, seq_done_out
  );

  modport slave (
    input  seq_valid_in, seq_urgn_in, seq_agu_address_in,
    output seq_ready_out, seq_agu_control_out, seq_agu_urgn_out,
           seq_rom_address_out, seq_mac_load_out, seq_mac_step_out,
           seq_busy_out, seq_done_out
  );

endinterface

// File: rtl/dds_seq_fold.sv
// Absolute value of a signed argument; the most negative code saturates to the max positive.
module dds_seq_fold #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] urgn_in,
  output logic [DATA_WIDTH-1:0] urgn_out
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  always_comb begin
    urgn_out = urgn_in;
    if (urgn_in == MOST_NEG) begin
      urgn_out = MOST_POS;
    end else if (urgn_in[DATA_WIDTH-1]) begin
      urgn_out = -urgn_in;
    end
  end

endmodule

// File: rtl/dds_poly_seq.sv
// Sequencer for the DDS polynomial cosine evaluator (AGU capture, ROM walk, Horner MAC strobes).
// Optional DDS_SEQ_FOLD_EN: fold the argument to |x| at accept (cosine even symmetry).
module dds_poly_seq import dds_seq_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int ORDER      = DEF_ORDER,
  parameter int ORD_WIDTH  = DEF_ORD_WIDTH
) (
  input  logic          seq_clock_in,
  input  logic          seq_reset_in,
  dds_poly_seq_if.slave bus
);

  localparam int ROM_W = rom_addr_width(ADDR_WIDTH, ORD_WIDTH);
  localparam logic [ORD_WIDTH-1:0] ORD_MAX = ORD_WIDTH'(ORDER);

  seq_state_e            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  agu_ctrl_q, agu_ctrl_d;
  logic [DATA_WIDTH-1:0] agu_urgn_q, agu_urgn_d;
  logic [ADDR_WIDTH-1:0] seg_q, seg_d;
  logic [ORD_WIDTH-1:0]  ord_q, ord_d;
  logic [ROM_W-1:0]      rom_addr_q, rom_addr_d;
  logic                  load_q, load_d;
  logic                  step_q, step_d;
  logic                  accept;
  logic [DATA_WIDTH-1:0] urgn_fold;

`ifdef DDS_SEQ_FOLD_EN
  dds_seq_fold #(.DATA_WIDTH(DATA_WIDTH)) u_fold (
    .urgn_in  (bus.seq_urgn_in),
    .urgn_out (urgn_fold)
  );
`else
  assign urgn_fold = bus.seq_urgn_in;
`endif

  // ready_q is high exactly in IDLE and DONE, so it doubles as the accept qualifier.
  assign accept = ready_q & bus.seq_valid_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CAPTURE;
      CAPTURE: state_d = SEG;
      SEG:     state_d = EVAL;
      EVAL:    if (ord_q == '0) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = accept ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the upcoming state.
  always_comb begin
    ready_d    = (state_d == IDLE) || (state_d == DONE);
    busy_d     = !ready_d;
    done_d     = (state_q == DRAIN);
    agu_ctrl_d = (state_d == CAPTURE);
    agu_urgn_d = accept ? urgn_fold : agu_urgn_q;
    seg_d      = seg_q;
    ord_d      = ord_q;
    rom_addr_d = rom_addr_q;
    if (state_q == SEG) begin
      seg_d      = bus.seq_agu_address_in;
      ord_d      = ORD_MAX;
      rom_addr_d = {bus.seq_agu_address_in, ORD_MAX};
    end else if ((state_q == EVAL) && (ord_q != '0)) begin
      ord_d      = ord_q - 1'b1;
      rom_addr_d = {seg_q, ord_d};
    end
    // ROM data lags its address by one cycle: the top-order coefficient loads, the rest step.
    load_d = (state_q == EVAL) && (ord_q == ORD_MAX);
    step_d = (state_q == EVAL) && (ord_q != ORD_MAX);
  end

  always_ff @(posedge seq_clock_in or posedge seq_reset_in) begin
    if (seq_reset_in) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      agu_ctrl_q <= 1'b0;
      agu_urgn_q <= '0;
      seg_q      <= '0;
      ord_q      <= '0;
      rom_addr_q <= '0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      agu_ctrl_q <= agu_ctrl_d;
      agu_urgn_q <= agu_urgn_d;
      seg_q      <= seg_d;
      ord_q      <= ord_d;
      rom_addr_q <= rom_addr_d;
      load_q     <= load_d;
      step_q     <= step_d;
    end
  end

  assign bus.seq_ready_out       = ready_q;
  assign bus.seq_busy_out        = busy_q;
  assign bus.seq_done_out        = done_q;
  assign bus.seq_agu_control_out = agu_ctrl_q;
  assign bus.seq_agu_urgn_out    = agu_urgn_q;
  assign bus.seq_rom_address_out = rom_addr_q;
  assign bus.seq_mac_load_out    = load_q;
  assign bus.seq_mac_step_out    = step_q;

endmodule

// File: tb/tb_dds_poly_seq.sv
// Self-checking bench for dds_poly_seq with a registered AGU model (segment = arg[14:10], 0 if negative).
module tb_dds_poly_seq;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int ORDER = 3;
  localparam int OW    = 2;

  typedef struct packed {
    logic [DW-1:0] urgn;
    logic [AW-1:0] seg;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      checks = 0;
  int      failures = 0;
  exp_t    sb_q[$];
  logic [AW-1:0] agu_seg_q;

  dds_poly_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ORD_WIDTH(OW)) bus ();

  dds_poly_seq #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ORDER      (ORDER),
    .ORD_WIDTH  (OW)
  ) dut (
    .seq_clock_in (clk),
    .seq_reset_in (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) agu_seg_q <= '0;
    else if (bus.seq_agu_control_out)
      agu_seg_q <= bus.seq_agu_urgn_out[DW-1] ? '0 : bus.seq_agu_urgn_out[14:10];
  end
  assign bus.seq_agu_address_in = agu_seg_q;

  // Expected {agu_control, busy, ready, done, mac_load, mac_step} at cycle c after accept.
  function automatic logic [5:0] exp_flags(input int c);
    if (c < 1 || c > 8) return 6'b001000;
    return {c == 1, c <= 7, c == 8, c == 8, c == 4, (c >= 5) && (c <= 7)};
  endfunction

  function automatic logic [5:0] obs_flags();
    return {bus.seq_agu_control_out, bus.seq_busy_out, bus.seq_ready_out,
            bus.seq_done_out, bus.seq_mac_load_out, bus.seq_mac_step_out};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.seq_valid_in = 1'b0;
    bus.seq_urgn_in  = '0;
    #12;
    checks++;
    if (obs_flags() !== 6'b001000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=%b", obs_flags(), 6'b001000);
    end
    checks++;
    if ({bus.seq_rom_address_out, bus.seq_agu_urgn_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data got rom=%h urgn=%h want 0", bus.seq_rom_address_out, bus.seq_agu_urgn_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_segment_walk(input logic [DW-1:0] arg, input logic [DW-1:0] exp_urgn,
                                   input logic [AW-1:0] exp_seg, input string tag);
    exp_t e;
    logic [AW+OW-1:0] exp_addr;
    @(negedge clk);
    checks++;
    if (bus.seq_ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready_before got=%b want=1", tag, bus.seq_ready_out);
    end
    bus.seq_valid_in = 1'b1;
    bus.seq_urgn_in  = arg;
    sb_q.push_back('{urgn: exp_urgn, seg: exp_seg});
    e = '0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.seq_valid_in = 1'b0;
        bus.seq_urgn_in  = '0;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL %s scoreboard_empty got=0 want=1", tag);
        end else begin
          e = sb_q.pop_front();
          if (bus.seq_agu_urgn_out !== e.urgn) begin
            failures++;
            $display("[TB] FAIL %s agu_urgn got=%h want=%h", tag, bus.seq_agu_urgn_out, e.urgn);
          end
        end
      end
      checks++;
      if (obs_flags() !== exp_flags(cyc)) begin
        failures++;
        $display("[TB] FAIL %s flags cyc=%0d got=%b want=%b", tag, cyc, obs_flags(), exp_flags(cyc));
      end
      if (cyc >= 3 && cyc <= 6) begin
        exp_addr = {e.seg, OW'(ORDER - (cyc - 3))};
        checks++;
        if (bus.seq_rom_address_out !== exp_addr) begin
          failures++;
          $display("[TB] FAIL %s rom_addr cyc=%0d got=%h want=%h", tag, cyc, bus.seq_rom_address_out, exp_addr);
        end
      end
    end
  endtask

  task automatic test_fold();
`ifdef DDS_SEQ_FOLD_EN
    test_segment_walk(16'hEC00, 16'h1400, 5'd5, "fold");
    test_segment_walk(16'h8000, 16'h7FFF, 5'd31, "fold_edge");
`else
    test_segment_walk(16'hEC00, 16'hEC00, 5'd0, "nofold");
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [AW+OW-1:0] exp_addr;
    int c;
    @(negedge clk);
    bus.seq_valid_in = 1'b1;
    bus.seq_urgn_in  = 16'h1400;
    sb_q.push_back('{urgn: 16'h1400, seg: 5'd5});
    sb_q.push_back('{urgn: 16'h2C00, seg: 5'd11});
    e = '0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      c = (cyc == 17) ? 9 : ((cyc - 1) % 8) + 1;
      if (cyc == 1) bus.seq_urgn_in = 16'h2C00;
      if (cyc == 9) bus.seq_valid_in = 1'b0;
      if (c == 1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL b2b scoreboard_empty cyc=%0d got=0 want=1", cyc);
        end else begin
          e = sb_q.pop_front();
          if (bus.seq_agu_urgn_out !== e.urgn) begin
            failures++;
            $display("[TB] FAIL b2b agu_urgn cyc=%0d got=%h want=%h", cyc, bus.seq_agu_urgn_out, e.urgn);
          end
        end
      end
      checks++;
      if (obs_flags() !== exp_flags(c)) begin
        failures++;
        $display("[TB] FAIL b2b flags cyc=%0d got=%b want=%b", cyc, obs_flags(), exp_flags(c));
      end
      if (c >= 3 && c <= 6) begin
        exp_addr = {e.seg, OW'(ORDER - (c - 3))};
        checks++;
        if (bus.seq_rom_address_out !== exp_addr) begin
          failures++;
          $display("[TB] FAIL b2b rom_addr cyc=%0d got=%h want=%h", cyc, bus.seq_rom_address_out, exp_addr);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    bus.seq_valid_in = 1'b1;
    bus.seq_urgn_in  = 16'h1400;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (obs_flags() !== exp_flags(cyc)) begin
        failures++;
        $display("[TB] FAIL busy_ignore flags cyc=%0d got=%b want=%b", cyc, obs_flags(), exp_flags(cyc));
      end
      if (cyc == 1) bus.seq_valid_in = 1'b0;
      if (cyc == 2) begin
        bus.seq_valid_in = 1'b1;
        bus.seq_urgn_in  = 16'h7C00;
      end
      if (cyc == 5) bus.seq_valid_in = 1'b0;
    end
    checks++;
    if (bus.seq_agu_urgn_out !== 16'h1400) begin
      failures++;
      $display("[TB] FAIL busy_ignore agu_urgn got=%h want=%h", bus.seq_agu_urgn_out, 16'h1400);
    end
    bus.seq_urgn_in = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.seq_valid_in = 1'b1;
    bus.seq_urgn_in  = 16'h1400;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.seq_valid_in = 1'b0;
    end
    checks++;
    if (obs_flags() !== exp_flags(4)) begin
      failures++;
      $display("[TB] FAIL reset_mid pre flags got=%b want=%b", obs_flags(), exp_flags(4));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_flags() !== 6'b001000) begin
      failures++;
      $display("[TB] FAIL reset_mid flags got=%b want=%b", obs_flags(), 6'b001000);
    end
    checks++;
    if (bus.seq_rom_address_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid rom_addr got=%h want=0", bus.seq_rom_address_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      checks++;
      if ({bus.seq_done_out, bus.seq_busy_out} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_mid quiet cyc=%0d got done/busy=%b want=00", cyc,
                 {bus.seq_done_out, bus.seq_busy_out});
      end
    end
    test_segment_walk(16'h1400, 16'h1400, 5'd5, "after_reset");
  endtask

  initial begin
    bus.seq_valid_in = 1'b0;
    bus.seq_urgn_in  = '0;
    test_reset();
    test_segment_walk(16'h1400, 16'h1400, 5'd5, "walk_seg5");
    test_segment_walk(16'h0200, 16'h0200, 5'd0, "walk_subseg");
    test_segment_walk(16'h7C00, 16'h7C00, 5'd31, "walk_seg31");
    test_fold();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
